uc_sequencer: RTL

Multi-cycle control sequencer for the 4-bit X/Y/Z/ULA datapath. It fetches instructions from the program memory, decodes them and drives the register transfer codes and ULA operation for one execute cycle. It also owns the program counter, including jumps, halt and single-step.

---
 rtl/uc_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/uc_sequencer.sv
// Multi-cycle control sequencer for the 4-bit X/Y/Z/ULA datapath.
// Fetches, decodes and executes one instruction per three cycles; owns the PC.
module uc_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    input  logic [3:0] mem_func,
    input  logic [3:0] mem_value,
    input  logic       y_zero,
    output logic [3:0] pc_addr,
    output logic [1:0] tX,
    output logic [1:0] tY,
    output logic [1:0] tZ,
    output logic       tULA,
    output logic       busy,
    output logic       halted,
    output logic       illegal,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_STEPWAIT, S_HALT
    } state_t;

    typedef struct packed {
        logic [1:0] tx;
        logic [1:0] ty;
        logic [1:0] tz;
        logic       ula;
    } ctrl_t;

    localparam logic [1:0] R_HOLD = 2'b00, R_LOAD = 2'b01, R_SHR = 2'b10, R_CLR = 2'b11;

    localparam logic [3:0] OP_LDX  = 4'h1, OP_ADD  = 4'h2, OP_SUB = 4'h3, OP_MOVZ = 4'h4,
                           OP_CLR  = 4'h5, OP_SHRY = 4'h6, OP_JMP = 4'h7, OP_JZ   = 4'h8,
                           OP_HALT = 4'hF;

    state_t     state, state_nxt;
    logic [3:0] pc, pc_nxt, ir, opr;
    logic [7:0] count;
    logic       ill;
    ctrl_t      ctrl;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ctrl      = '0;
        case (state)
            S_IDLE:     if (start) state_nxt = S_FETCH;
            S_FETCH:    state_nxt = S_DECODE;
            S_DECODE:   state_nxt = S_EXEC;
            S_EXEC: begin
                pc_nxt = pc + 4'd1;
                case (ir)
                    OP_LDX:  ctrl.tx = R_LOAD;
                    OP_ADD:  ctrl.ty = R_LOAD;
                    OP_SUB:  begin ctrl.ty = R_LOAD; ctrl.ula = 1'b1; end
                    OP_MOVZ: ctrl.tz = R_LOAD;
                    OP_CLR:  begin ctrl.tx = R_CLR; ctrl.ty = R_CLR; ctrl.tz = R_CLR; end
                    OP_SHRY: ctrl.ty = R_SHR;
                    OP_JMP:  pc_nxt = opr;
                    OP_JZ:   if (y_zero) pc_nxt = opr;
                    OP_HALT: pc_nxt = pc;
                    default: ;
                endcase
                if (ir == OP_HALT)  state_nxt = S_HALT;
                else if (step_mode) state_nxt = S_STEPWAIT;
                else                state_nxt = S_FETCH;
            end
            S_STEPWAIT: if (step) state_nxt = S_FETCH;
            S_HALT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = 4'd0;
                end
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            opr   <= '0;
            count <= '0;
            ill   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_FETCH) begin
                ir  <= mem_func;
                opr <= mem_value;
            end
            if (state == S_EXEC) begin
                if (count != 8'hFF) count <= count + 8'd1;
                // opcodes 9..E are undefined: run as NOP, flag sticky until reset
                if (ir >= 4'h9 && ir <= 4'hE) ill <= 1'b1;
            end
        end
    end

    assign pc_addr     = pc;
    assign tX          = ctrl.tx;
    assign tY          = ctrl.ty;
    assign tZ          = ctrl.tz;
    assign tULA        = ctrl.ula;
    assign busy        = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted      = (state == S_HALT);
    assign illegal     = ill;
    assign instr_count = count;

endmodule
